// File: rtl/jt51_noise_sched_if.sv
// Bus bundle between the JT51 register/timing logic and the noise scheduler.
// The master drives the tick, register writes and LFSR bit; the slave returns the step pulse and register view.
interface jt51_noise_sched_if #(
    parameter int NFRQ_W = 5
);
    logic              cen;
    logic              wr;
    logic [7:0]        din;
    logic              lfsr_out;
    logic              base;
    logic              ne;
    logic [NFRQ_W-1:0] nfrq;
    logic              pend;
    logic              noise;

    modport master (
        output cen, wr, din, lfsr_out,
        input  base, ne, nfrq, pend, noise
    );

    modport slave (
        input  cen, wr, din, lfsr_out,
        output base, ne, nfrq, pend, noise
    );
endinterface

// File: rtl/jt51_noise_sched.sv
// JT51 noise scheduler: holds NE/NFRQ, divides the sample tick to the noise rate,
// pulses base to step the LFSR and latches the shifted bit for the channel-8 path.
module jt51_noise_sched #(
    parameter int NFRQ_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    jt51_noise_sched_if.slave bus
);

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] CAPT  = 2'd3;

    logic [1:0]        state;
    logic [NFRQ_W-1:0] cnt;
    logic [NFRQ_W-1:0] nfrq_r;
    logic [NFRQ_W-1:0] pnfrq;
    logic              ne_r;
    logic              pend_r;
    logic              noise_r;

    logic              wr_ne;
    logic [NFRQ_W-1:0] wr_nfrq;
    logic [NFRQ_W-1:0] term;
    logic              hit;

    assign wr_ne   = bus.din[7];
    assign wr_nfrq = bus.din[NFRQ_W-1:0];
    // Counting up to the complement gives a period of 2^NFRQ_W - nfrq ticks.
    assign term    = ~nfrq_r;
    assign hit     = bus.cen && (cnt == term);

    // Bits of din between NFRQ and NE carry no meaning for this register.
    wire unused_din = &{1'b0, bus.din};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OFF;
            cnt     <= '0;
            nfrq_r  <= '0;
            pnfrq   <= '0;
            ne_r    <= 1'b0;
            pend_r  <= 1'b0;
            noise_r <= 1'b0;
        end else if (state == OFF) begin
            if (bus.wr) begin
                nfrq_r <= wr_nfrq;
                cnt    <= '0;
                if (wr_ne) begin
                    ne_r  <= 1'b1;
                    state <= RUN;
                end
            end
        end else begin
            if (bus.cen)
                cnt <= hit ? '0 : cnt + NFRQ_W'(1);

            // The boundary consumes the value pending before this cycle's write.
            if (hit && pend_r) begin
                nfrq_r <= pnfrq;
                pend_r <= 1'b0;
            end

            case (state)
                RUN:     if (hit) state <= ISSUE;
                ISSUE:   state <= CAPT;
                CAPT: begin
                    noise_r <= bus.lfsr_out;
                    state   <= RUN;
                end
                default: state <= OFF;
            endcase

            // NOTE: these non-blocking assignments come last on purpose; the last
            // NBA to a register wins, so a write overrides the boundary updates above.
            if (bus.wr) begin
                if (wr_ne) begin
                    pnfrq  <= wr_nfrq;
                    pend_r <= 1'b1;
                end else begin
                    state  <= OFF;
                    ne_r   <= 1'b0;
                    nfrq_r <= wr_nfrq;
                    pend_r <= 1'b0;
                    cnt    <= '0;
                end
            end
        end
    end

    assign bus.base  = (state == ISSUE);
    assign bus.ne    = ne_r;
    assign bus.nfrq  = nfrq_r;
    assign bus.pend  = pend_r;
    assign bus.noise = noise_r;

endmodule

// File: tb/tb_jt51_noise_sched.sv
// Directed bench for jt51_noise_sched: reset/idle, rate division, deferred writes,
// disable, write/boundary collisions and reset during a step pulse.
module tb_jt51_noise_sched;

    localparam int         NFRQ_W = 5;
    localparam logic [16:0] SEED  = 17'h0A5C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] lfsr;
    int          checks   = 0;
    int          failures = 0;
    int          base_total = 0;
    int          wide_err   = 0;
    logic        prev_base  = 1'b0;

    jt51_noise_sched_if #(.NFRQ_W(NFRQ_W)) bus ();

    jt51_noise_sched #(.NFRQ_W(NFRQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in LFSR: steps on each sampled base pulse.
    always @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (bus.base)
            lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
    end
    assign bus.lfsr_out = lfsr[0];

    always @(posedge clk) begin
        if (bus.base) base_total <= base_total + 1;
        if (bus.base && prev_base) wide_err <= wide_err + 1;
        prev_base <= bus.base;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        bus.wr  = 1'b1;
        bus.din = d;
        step();
        bus.wr  = 1'b0;
        bus.din = 8'h00;
    endtask

    // One sample tick, 4 clk apart; saw_base is base one clk after the cen edge.
    task automatic cen_tick(output logic saw_base);
        bus.cen = 1'b1;
        step();
        saw_base = bus.base;
        bus.cen = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic ticks_to_base(input int limit, output int n);
        logic sb;
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            cen_tick(sb);
            if (sb) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   b0;
        logic sb;
        logic frozen;

        bus.cen = 1'b0;
        bus.wr  = 1'b0;
        bus.din = 8'h00;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_base",  32'(bus.base),  0);
        check("rst_ne",    32'(bus.ne),    0);
        check("rst_nfrq",  32'(bus.nfrq),  0);
        check("rst_pend",  32'(bus.pend),  0);
        check("rst_noise", 32'(bus.noise), 0);

        // Idle: 100 ticks with no write
        b0 = base_total;
        for (int i = 0; i < 100; i++) cen_tick(sb);
        check("idle_base_count", 32'(base_total - b0), 0);
        check("idle_ne",    32'(bus.ne),    0);
        check("idle_nfrq",  32'(bus.nfrq),  0);
        check("idle_pend",  32'(bus.pend),  0);
        check("idle_noise", 32'(bus.noise), 0);

        // Enable at NFRQ=31: one pulse per tick, noise follows the shifted bit
        write(8'h9F);
        check("en31_ne",   32'(bus.ne),   1);
        check("en31_nfrq", 32'(bus.nfrq), 31);
        check("en31_pend", 32'(bus.pend), 0);
        for (int i = 0; i < 8; i++) begin
            cen_tick(sb);
            check("en31_base", 32'(sb), 1);
            check("en31_noise", 32'(bus.noise), 32'(lfsr[0]));
        end

        // Disable, then enable at NFRQ=0: 32 ticks per period
        write(8'h00);
        check("dis_ne",   32'(bus.ne),   0);
        check("dis_nfrq", 32'(bus.nfrq), 0);
        write(8'h80);
        check("en0_ne", 32'(bus.ne), 1);
        ticks_to_base(40, n);
        check("en0_first_period", 32'(n), 32);
        ticks_to_base(40, n);
        check("en0_period", 32'(n), 32);

        // Deferred change at cnt=10
        for (int i = 0; i < 10; i++) cen_tick(sb);
        write(8'h9C);
        check("defer_pend", 32'(bus.pend), 1);
        check("defer_nfrq_held", 32'(bus.nfrq), 0);
        ticks_to_base(40, n);
        check("defer_rest_of_period", 32'(n), 22);
        check("defer_nfrq_applied", 32'(bus.nfrq), 28);
        check("defer_pend_clear", 32'(bus.pend), 0);
        ticks_to_base(40, n);
        check("defer_period4_a", 32'(n), 4);
        ticks_to_base(40, n);
        check("defer_period4_b", 32'(n), 4);

        // Disable mid-period
        cen_tick(sb);
        cen_tick(sb);
        write(8'h1F);
        check("mid_dis_ne",   32'(bus.ne),   0);
        check("mid_dis_nfrq", 32'(bus.nfrq), 31);
        check("mid_dis_pend", 32'(bus.pend), 0);
        frozen = bus.noise;
        b0 = base_total;
        for (int i = 0; i < 10; i++) cen_tick(sb);
        check("mid_dis_no_base", 32'(base_total - b0), 0);
        check("mid_dis_noise_frozen", 32'(bus.noise), 32'(frozen));
        write(8'h9E);
        ticks_to_base(40, n);
        check("reen_period_from_zero", 32'(n), 2);

        // Collision: enable write on a terminal tick
        cen_tick(sb);
        check("col_pre_no_base", 32'(sb), 0);
        bus.cen = 1'b1;
        bus.wr  = 1'b1;
        bus.din = 8'h90;
        step();
        check("col_base",      32'(bus.base), 1);
        check("col_nfrq_kept", 32'(bus.nfrq), 30);
        check("col_pend",      32'(bus.pend), 1);
        bus.cen = 1'b0;
        bus.wr  = 1'b0;
        bus.din = 8'h00;
        step();
        step();
        step();
        ticks_to_base(40, n);
        check("col_next_period", 32'(n), 2);
        check("col_nfrq_applied", 32'(bus.nfrq), 16);
        check("col_pend_clear",   32'(bus.pend), 0);
        ticks_to_base(40, n);
        check("col_period16", 32'(n), 16);

        // Collision: disable write on a terminal tick
        b0 = base_total;
        for (int i = 0; i < 15; i++) cen_tick(sb);
        check("col_dis_pre_no_base", 32'(base_total - b0), 0);
        bus.cen = 1'b1;
        bus.wr  = 1'b1;
        bus.din = 8'h00;
        step();
        check("col_dis_base", 32'(bus.base), 0);
        check("col_dis_ne",   32'(bus.ne),   0);
        check("col_dis_nfrq", 32'(bus.nfrq), 0);
        check("col_dis_pend", 32'(bus.pend), 0);
        bus.cen = 1'b0;
        bus.wr  = 1'b0;
        step();
        step();
        step();
        b0 = base_total;
        for (int i = 0; i < 5; i++) cen_tick(sb);
        check("col_dis_stays_off", 32'(base_total - b0), 0);

        // Reset during ISSUE
        write(8'h9F);
        bus.cen = 1'b1;
        step();
        bus.cen = 1'b0;
        check("rst_issue_pre_base", 32'(bus.base), 1);
        rst = 1'b1;
        step();
        check("rst_issue_base",  32'(bus.base),  0);
        check("rst_issue_ne",    32'(bus.ne),    0);
        check("rst_issue_nfrq",  32'(bus.nfrq),  0);
        check("rst_issue_noise", 32'(bus.noise), 0);
        rst = 1'b0;
        step();
        step();

        check("base_width", 32'(wide_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
